// File: rtl/rca_exec_ctrl.sv
// RCA execution controller: in-order instruction queue feeding a sequencer that drives the PR grid and writeback.
// Optional WAIT timeout with FLUSH recovery is enabled by defining RCA_EXEC_TIMEOUT_EN.
module rca_exec_ctrl #(
    parameter int XLEN            = 32,
    parameter int NUM_RCAS        = 4,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 5,
    parameter int ID_W            = 3,
    parameter int QUEUE_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_new_request,
    output logic                              issue_ready,
    input  logic [ID_W-1:0]                   issue_id,
    input  logic                              issue_use_instr,
    input  logic [$clog2(NUM_RCAS)-1:0]       issue_rca_sel,
    input  logic                              issue_fb,
    input  logic [NUM_READ_PORTS*XLEN-1:0]    issue_rs,
    output logic [NUM_READ_PORTS*XLEN-1:0]    grid_rs_data,
    output logic                              grid_rs_valid,
    output logic [$clog2(NUM_RCAS)-1:0]       grid_rca_sel,
    output logic                              grid_fb,
    output logic                              grid_flush,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0]   grid_res_data,
    input  logic [NUM_WRITE_PORTS-1:0]        grid_res_valid,
    output logic                              grid_res_pop,
    output logic                              wb_done,
    output logic [ID_W-1:0]                   wb_id,
    output logic [NUM_WRITE_PORTS*XLEN-1:0]   wb_rd,
    output logic                              wb_err,
    input  logic                              wb_ack
);

    localparam int SEL_W = $clog2(NUM_RCAS);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RS_W  = NUM_READ_PORTS * XLEN;
    localparam int RD_W  = NUM_WRITE_PORTS * XLEN;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

`ifdef RCA_EXEC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECONF = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_WB     = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECONF = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WB     = 3'd5
    } state_t;
`endif

    state_t state_r, state_s;

    logic [ID_W-1:0]  q_id_r  [QUEUE_DEPTH];
    logic             q_use_r [QUEUE_DEPTH];
    logic [SEL_W-1:0] q_sel_r [QUEUE_DEPTH];
    logic             q_fb_r  [QUEUE_DEPTH];
    logic [RS_W-1:0]  q_rs_r  [QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_s;
    logic             push_s, pop_s, all_vld_s;

    logic [SEL_W-1:0] run_sel_r;
    logic             run_fb_r;
    logic [RS_W-1:0]  run_rs_r;
    logic [SEL_W-1:0] last_rca_r;
    logic             last_vld_r;

    logic             issue_ready_r, grid_rs_valid_r, grid_flush_r, grid_res_pop_r, wb_done_r;
    logic [ID_W-1:0]  wb_id_r;
    logic [RD_W-1:0]  wb_rd_r;

`ifdef RCA_EXEC_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt_r;
    logic             wb_err_r;
`endif

    // Next-state, queue push/pop and occupancy decode.
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        push_s    = issue_new_request & issue_ready_r;
        all_vld_s = &grid_res_valid;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s = 1'b1;
                    if (!q_use_r[rd_ptr_r]) begin
                        state_s = ST_WB;
                    end else if (!last_vld_r || (q_sel_r[rd_ptr_r] != last_rca_r)) begin
                        state_s = ST_RECONF;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECONF: state_s = ST_LOAD;
            ST_LOAD:   state_s = ST_WAIT;
            ST_WAIT: begin
                if (all_vld_s) begin
                    state_s = ST_WB;
`ifdef RCA_EXEC_TIMEOUT_EN
                end else if (to_cnt_r == TO_LAST_C) begin
                    state_s = ST_FLUSH;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
`ifdef RCA_EXEC_TIMEOUT_EN
            ST_FLUSH:  state_s = ST_WB;
`endif
            ST_WB: begin
                if (wb_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WB;
                end
            end
            default:   state_s = ST_IDLE;
        endcase
        count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Queue payload storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_id_r[wr_ptr_r]  <= issue_id;
            q_use_r[wr_ptr_r] <= issue_use_instr;
            q_sel_r[wr_ptr_r] <= issue_rca_sel;
            q_fb_r[wr_ptr_r]  <= issue_fb;
            q_rs_r[wr_ptr_r]  <= issue_rs;
        end
    end

    // State, queue control, running instruction and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            issue_ready_r   <= 1'b1;
            run_sel_r       <= {SEL_W{1'b0}};
            run_fb_r        <= 1'b0;
            run_rs_r        <= {RS_W{1'b0}};
            last_rca_r      <= {SEL_W{1'b0}};
            last_vld_r      <= 1'b0;
            grid_rs_valid_r <= 1'b0;
            grid_flush_r    <= 1'b0;
            grid_res_pop_r  <= 1'b0;
            wb_done_r       <= 1'b0;
            wb_id_r         <= {ID_W{1'b0}};
            wb_rd_r         <= {RD_W{1'b0}};
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            issue_ready_r <= (count_s != DEPTH_C);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            // A pop also starts a fresh writeback record, zero data unless the grid fills it.
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
                run_sel_r <= q_sel_r[rd_ptr_r];
                run_fb_r  <= q_fb_r[rd_ptr_r];
                run_rs_r  <= q_rs_r[rd_ptr_r];
                wb_id_r   <= q_id_r[rd_ptr_r];
                wb_rd_r   <= {RD_W{1'b0}};
            end
            if (state_r == ST_RECONF) begin
                last_rca_r <= run_sel_r;
                last_vld_r <= 1'b1;
            end
`ifdef RCA_EXEC_TIMEOUT_EN
            if (state_r == ST_FLUSH) begin
                last_vld_r <= 1'b0;
            end
`endif
            if ((state_r == ST_WAIT) && all_vld_s) begin
                wb_rd_r <= grid_res_data;
            end
            grid_res_pop_r  <= (state_r == ST_WAIT) && all_vld_s;
            grid_rs_valid_r <= (state_s == ST_LOAD);
`ifdef RCA_EXEC_TIMEOUT_EN
            grid_flush_r    <= (state_s == ST_RECONF) || (state_s == ST_FLUSH);
`else
            grid_flush_r    <= (state_s == ST_RECONF);
`endif
            wb_done_r       <= (state_s == ST_WB);
        end
    end

`ifdef RCA_EXEC_TIMEOUT_EN
    // WAIT-cycle counter and error flag for the timeout path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= {TO_W{1'b0}};
            wb_err_r <= 1'b0;
        end else begin
            if (state_r == ST_LOAD) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (state_r == ST_WAIT) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (pop_s) begin
                wb_err_r <= 1'b0;
            end else if (state_r == ST_FLUSH) begin
                wb_err_r <= 1'b1;
            end
        end
    end
    assign wb_err = wb_err_r;
`else
    assign wb_err = 1'b0;
`endif

    assign issue_ready   = issue_ready_r;
    assign grid_rs_data  = run_rs_r;
    assign grid_rs_valid = grid_rs_valid_r;
    assign grid_rca_sel  = run_sel_r;
    assign grid_fb       = run_fb_r;
    assign grid_flush    = grid_flush_r;
    assign grid_res_pop  = grid_res_pop_r;
    assign wb_done       = wb_done_r;
    assign wb_id         = wb_id_r;
    assign wb_rd         = wb_rd_r;

endmodule
